mc_controller: RTL and testbench

- Multicycle MIPS control unit: the producer side of the ALU control interface.
- Sequences each instruction through a Moore FSM.
- Per state, it drives datapath enables, mux selects and the 3-bit ALU operation code consumed by the ALU.
- Sits beside the shared datapath: consumes opcode/funct from the instruction register and the ALU zero flag.

---
 rtl/mips_ctrl_pkg.sv | 164 ++++++++++++++++
 rtl/mc_controller_alu_decoder.sv | 23 ++
 rtl/mc_controller.sv | 65 ++++++
 tb/tb_mc_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants, ALU operation codes and the per-state control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        IMMEX   = 4'd10,
        IMMWB   = 4'd11,
        JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUCONT_AND = 3'b000;
    localparam logic [2:0] ALUCONT_OR  = 3'b001;
    localparam logic [2:0] ALUCONT_ADD = 3'b010;
    localparam logic [2:0] ALUCONT_SUB = 3'b110;
    localparam logic [2:0] ALUCONT_SLT = 3'b111;

    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [1:0] pcsrc;
        logic [2:0] alucont;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: op_supported = 1'b1;
            default:                                 op_supported = 1'b0;
        endcase
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        next_state = FETCH;
        case (s)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:                      next_state = MEMADR;
                    OP_RTYPE:                          next_state = RTYPEEX;
                    OP_BEQ:                            next_state = BEQEX;
                    OP_BNE:                            next_state = BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = IMMEX;
                    OP_J:                              next_state = JEX;
                    default:                           next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            IMMEX:   next_state = IMMWB;
            default: next_state = FETCH;
        endcase
    endfunction

    // Control word for state s; op only matters for IMMEX, whose op is stable by then.
    function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.alucont = ALUCONT_ADD;
                c.pcwrite = 1'b1;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
                c.extop   = 1'b1;
                c.alucont = ALUCONT_ADD;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.extop   = 1'b1;
                c.alucont = ALUCONT_ADD;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.alucont = ALUCONT_ADD;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX, BNEEX: begin
                c.alusrca = 1'b1;
                c.alucont = ALUCONT_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = (s == BEQEX);
                c.bne     = (s == BNEEX);
            end
            IMMEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (op)
                    OP_ANDI: c.alucont = ALUCONT_AND;
                    OP_ORI:  c.alucont = ALUCONT_OR;
                    OP_SLTI: begin
                        c.extop   = 1'b1;
                        c.alucont = ALUCONT_SLT;
                    end
                    default: begin
                        c.extop   = 1'b1;
                        c.alucont = ALUCONT_ADD;
                    end
                endcase
            end
            IMMWB: c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// R-type funct field to ALU operation decode; unknown functs fall back to ADD and flag illegal.
import mips_ctrl_pkg::*;

module alu_decoder (
    input  logic [5:0] funct,
    output logic [2:0] alucont,
    output logic       illegal
);

    always_comb begin
        alucont = ALUCONT_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alucont = ALUCONT_ADD;
            FN_SUB:  alucont = ALUCONT_SUB;
            FN_AND:  alucont = ALUCONT_AND;
            FN_OR:   alucont = ALUCONT_OR;
            FN_SLT:  alucont = ALUCONT_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath enables, mux selects and ALU op.
import mips_ctrl_pkg::*;

module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       extop,
    output logic [1:0] pcsrc,
    output logic [2:0] alucont,
    output logic       illegal,
    output state_t     dbg_state
);

    state_t     state;
    ctrl_t      ctrl;
    logic [2:0] dec_alucont;
    logic       dec_illegal;

    alu_decoder u_alu_decoder (
        .funct   (funct),
        .alucont (dec_alucont),
        .illegal (dec_illegal)
    );

    // The control word is registered alongside the state, so it always matches state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH, 6'b000000);
        end else begin
            state <= next_state(state, op);
            ctrl  <= state_ctrl(next_state(state, op), op);
        end
    end

    // Reset leaves FETCH values in ctrl; the write enables are masked while reset_n is low.
    assign memwrite = ctrl.memwrite & reset_n;
    assign irwrite  = ctrl.irwrite  & reset_n;
    assign regwrite = ctrl.regwrite & reset_n;
    assign pcen     = reset_n & (ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.bne & ~zero));
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign extop    = ctrl.extop;
    assign pcsrc    = ctrl.pcsrc;
    assign alucont  = (state == RTYPEEX) ? dec_alucont : ctrl.alucont;
    assign illegal  = reset_n & (((state == DECODE) & ~op_supported(op)) |
                                 ((state == RTYPEEX) & dec_illegal));
    assign dbg_state = state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected output vectors are queued
// per instruction and popped as each cycle is sampled on the falling edge.
import mips_ctrl_pkg::*;

module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       extop, illegal;
    logic [2:0] alucont;
    state_t     dbg_state;

    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       pcen;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [1:0] pcsrc;
        logic [2:0] alucont;
        logic       illegal;
    } obs_t;

    int compared = 0;
    int mismatched = 0;
    logic [16:0] exp_q[$];

    mc_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .pcen      (pcen),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .extop     (extop),
        .pcsrc     (pcsrc),
        .alucont   (alucont),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o = {memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca,
             alusrcb, extop, pcsrc, alucont, illegal};
        return o;
    endfunction

    // Expected output vectors per state, written from the state table.
    function automatic obs_t e_fetch();
        obs_t o = '0;
        o.irwrite = 1'b1; o.pcen = 1'b1; o.alusrcb = 2'b01; o.alucont = 3'b010;
        return o;
    endfunction

    function automatic obs_t e_rst();
        obs_t o = '0;
        o.alusrcb = 2'b01; o.alucont = 3'b010;
        return o;
    endfunction

    function automatic obs_t e_decode(input logic ill);
        obs_t o = '0;
        o.alusrcb = 2'b11; o.extop = 1'b1; o.alucont = 3'b010; o.illegal = ill;
        return o;
    endfunction

    function automatic obs_t e_memadr();
        obs_t o = '0;
        o.alusrca = 1'b1; o.alusrcb = 2'b10; o.extop = 1'b1; o.alucont = 3'b010;
        return o;
    endfunction

    function automatic obs_t e_memrd();
        obs_t o = '0;
        o.iord = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_memwb();
        obs_t o = '0;
        o.memtoreg = 1'b1; o.regwrite = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_memwr();
        obs_t o = '0;
        o.iord = 1'b1; o.memwrite = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_rex(input logic [2:0] alu, input logic ill);
        obs_t o = '0;
        o.alusrca = 1'b1; o.alucont = alu; o.illegal = ill;
        return o;
    endfunction

    function automatic obs_t e_rwb();
        obs_t o = '0;
        o.regdst = 1'b1; o.regwrite = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_br(input logic pc);
        obs_t o = '0;
        o.alusrca = 1'b1; o.alucont = 3'b110; o.pcsrc = 2'b01; o.pcen = pc;
        return o;
    endfunction

    function automatic obs_t e_immex(input logic ext, input logic [2:0] alu);
        obs_t o = '0;
        o.alusrca = 1'b1; o.alusrcb = 2'b10; o.extop = ext; o.alucont = alu;
        return o;
    endfunction

    function automatic obs_t e_immwb();
        obs_t o = '0;
        o.regwrite = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_jex();
        obs_t o = '0;
        o.pcsrc = 2'b10; o.pcen = 1'b1;
        return o;
    endfunction

    task automatic test_reset();
        logic       rseq[9];
        logic [5:0] oseq[9];
        obs_t       got, exp;
        rseq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        oseq = '{OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_J, OP_J, OP_J};
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_memadr());
        repeat (3) exp_q.push_back(e_rst());
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_jex());
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            reset_n = rseq[i];
            op = oseq[i];
            #1;
            got = sample();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL reset cyc%0d got=%h exp=%h", i, got, exp);
            end
            if (!rseq[i]) begin
                compared++;
                if (dbg_state !== FETCH) begin
                    mismatched++;
                    $display("FAIL reset_state cyc%0d got=%0d exp=%0d", i, dbg_state, FETCH);
                end
            end
        end
    endtask

    task automatic test_lw();
        obs_t got, exp;
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_memadr());
        exp_q.push_back(e_memrd());
        exp_q.push_back(e_memwb());
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op = OP_LW;
            #1;
            got = sample();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL lw cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn[5];
        logic [2:0] al[5];
        obs_t       got, exp;
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        al = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(e_fetch());
            exp_q.push_back(e_decode(1'b0));
            exp_q.push_back(e_rex(al[k], 1'b0));
            exp_q.push_back(e_rwb());
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                op = 6'b000000;
                funct = fn[k];
                #1;
                got = sample();
                exp = exp_q.pop_front();
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL rtype fn=%b cyc%0d got=%h exp=%h", fn[k], i, got, exp);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] bop[4];
        logic       bz[4];
        logic       bpc[4];
        obs_t       got, exp;
        bop = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        bz  = '{1'b1, 1'b0, 1'b0, 1'b1};
        bpc = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(e_fetch());
            exp_q.push_back(e_decode(1'b0));
            exp_q.push_back(e_br(bpc[k]));
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                op = bop[k];
                zero = bz[k];
                #1;
                got = sample();
                exp = exp_q.pop_front();
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL branch op=%b zero=%b cyc%0d got=%h exp=%h",
                             bop[k], bz[k], i, got, exp);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_imm();
        logic [5:0] iop[4];
        logic       iext[4];
        logic [2:0] ial[4];
        obs_t       got, exp;
        iop  = '{OP_ORI, OP_SLTI, OP_ADDI, OP_ANDI};
        iext = '{1'b0, 1'b1, 1'b1, 1'b0};
        ial  = '{3'b001, 3'b111, 3'b010, 3'b000};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(e_fetch());
            exp_q.push_back(e_decode(1'b0));
            exp_q.push_back(e_immex(iext[k], ial[k]));
            exp_q.push_back(e_immwb());
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                op = iop[k];
                #1;
                got = sample();
                exp = exp_q.pop_front();
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL imm op=%b cyc%0d got=%h exp=%h", iop[k], i, got, exp);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] oseq[9];
        logic [5:0] fseq[9];
        obs_t       got, exp;
        // Bad opcode (2 cycles), a jump to confirm the return to FETCH, then a bad funct.
        oseq = '{6'b111111, 6'b111111, OP_J, OP_J, OP_J, 6'b0, 6'b0, 6'b0, 6'b0};
        fseq = '{6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b1));
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_jex());
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_rex(3'b010, 1'b1));
        exp_q.push_back(e_rwb());
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            op = oseq[i];
            funct = fseq[i];
            #1;
            got = sample();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] oseq[16];
        obs_t       got, exp;
        oseq = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_J, OP_J, OP_J,
                 OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                 OP_LW, OP_LW, OP_LW, OP_LW, OP_LW};
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_memadr());
        exp_q.push_back(e_memwr());
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_jex());
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_immex(1'b1, 3'b010));
        exp_q.push_back(e_immwb());
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(1'b0));
        exp_q.push_back(e_memadr());
        exp_q.push_back(e_memrd());
        exp_q.push_back(e_memwb());
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            op = oseq[i];
            funct = 6'($urandom_range(0, 63));
            #1;
            got = sample();
            exp = exp_q.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL b2b cyc%0d op=%b got=%h exp=%h", i, oseq[i], got, exp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_imm();
        test_illegal();
        test_back_to_back();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
